alarm_mode_controller: RTL and testbench

- Top-level mode sequencer for the digital alarm clock.
- Consumes the one-cycle debounced button pulses (up/down/left/right/center) and walks the five-mode FSM: clock display, set time hours, set time minutes, set alarm hours, set alarm minutes.
- Drives the increment/decrement enables of the time and alarm counters, display source select and digit-blink mask.
- Compares current time against alarm time and raises/clears the ringing output.

---
 rtl/alarm_mode_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_alarm_mode_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_mode_controller.sv
// Mode sequencer for the digital alarm clock.
// Walks the clock/set-time/set-alarm modes from debounced button pulses, issues
// one-cycle count enables to the time and alarm counters, selects the display
// source and blink mask, and drives the alarm ringing output.
module alarm_mode_controller #(
    parameter int unsigned RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       center,
    input  logic       sec_tick,
    input  logic       blink_tick,
    input  logic [1:0] th1,
    input  logic [3:0] th2,
    input  logic [2:0] tm1,
    input  logic [3:0] tm2,
    input  logic [1:0] ah1,
    input  logic [3:0] ah2,
    input  logic [2:0] am1,
    input  logic [3:0] am2,
    output logic [2:0] mode,
    output logic       en_th,
    output logic       en_tm,
    output logic       en_ah,
    output logic       en_am,
    output logic       updown,
    output logic       hold_time,
    output logic       disp_alarm,
    output logic [3:0] blank_mask,
    output logic       alarm_en,
    output logic       ringing
);

    typedef enum logic [2:0] {
        ModeClk   = 3'd0,
        ModeSetTh = 3'd1,
        ModeSetTm = 3'd2,
        ModeSetAh = 3'd3,
        ModeSetAm = 3'd4
    } mode_e;

    typedef enum logic [2:0] {
        ActNone,
        ActCenter,
        ActRight,
        ActLeft,
        ActUp,
        ActDown
    } act_e;

    localparam logic [7:0] RingLimit = 8'(RING_SECS);

    // State and registered outputs
    mode_e      mode_q, mode_d;
    logic       en_th_q, en_th_d;
    logic       en_tm_q, en_tm_d;
    logic       en_ah_q, en_ah_d;
    logic       en_am_q, en_am_d;
    logic       updown_q, updown_d;
    logic       hold_time_q, hold_time_d;
    logic       disp_alarm_q, disp_alarm_d;
    logic [3:0] blank_mask_q, blank_mask_d;
    logic       alarm_en_q, alarm_en_d;
    logic       ringing_q, ringing_d;
    logic       phase_q, phase_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       match_q, match_d;

    // Decoded button action
    act_e       act_raw;
    act_e       act;
    logic       any_btn;
    logic       ring_set;
    logic       ring_timeout;
    logic       ring_clr;

    // Resolve coincident pulses to a single action; while ringing, every pulse
    // is only an acknowledge and carries no other action.
    always_comb begin
        act_raw = ActNone;
        if (center) begin
            act_raw = ActCenter;
        end else if (right) begin
            act_raw = ActRight;
        end else if (left) begin
            act_raw = ActLeft;
        end else if (up) begin
            act_raw = ActUp;
        end else if (down) begin
            act_raw = ActDown;
        end
        any_btn = up | down | left | right | center;
        act     = (ringing_q && any_btn) ? ActNone : act_raw;
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= ModeClk;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next-state: center enters/leaves setting, right/left rotate fields
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            ModeClk: begin
                if (act == ActCenter) mode_d = ModeSetTh;
            end
            ModeSetTh: begin
                if (act == ActCenter)     mode_d = ModeClk;
                else if (act == ActRight) mode_d = ModeSetTm;
                else if (act == ActLeft)  mode_d = ModeSetAm;
            end
            ModeSetTm: begin
                if (act == ActCenter)     mode_d = ModeClk;
                else if (act == ActRight) mode_d = ModeSetAh;
                else if (act == ActLeft)  mode_d = ModeSetTh;
            end
            ModeSetAh: begin
                if (act == ActCenter)     mode_d = ModeClk;
                else if (act == ActRight) mode_d = ModeSetAm;
                else if (act == ActLeft)  mode_d = ModeSetTm;
            end
            ModeSetAm: begin
                if (act == ActCenter)     mode_d = ModeClk;
                else if (act == ActRight) mode_d = ModeSetTh;
                else if (act == ActLeft)  mode_d = ModeSetAh;
            end
            default: mode_d = ModeClk;
        endcase
    end

    // Output next-state: enables, derived mode flags, blink mask and alarm
    always_comb begin
        en_th_d    = 1'b0;
        en_tm_d    = 1'b0;
        en_ah_d    = 1'b0;
        en_am_d    = 1'b0;
        updown_d   = updown_q;
        alarm_en_d = alarm_en_q;

        if (mode_q == ModeClk) begin
            if (act == ActUp) alarm_en_d = ~alarm_en_q;
        end else if (act == ActUp || act == ActDown) begin
            updown_d = (act == ActUp);
            case (mode_q)
                ModeSetTh: en_th_d = 1'b1;
                ModeSetTm: en_tm_d = 1'b1;
                ModeSetAh: en_ah_d = 1'b1;
                ModeSetAm: en_am_d = 1'b1;
                default:   ;
            endcase
        end

        // Flags follow the mode being entered so they line up with mode
        hold_time_d  = (mode_d == ModeSetTh) || (mode_d == ModeSetTm);
        disp_alarm_d = (mode_d == ModeSetAh) || (mode_d == ModeSetAm);

        // Phase restarts dark-free on each mode change so the new field shows
        if (mode_d != mode_q) begin
            phase_d = 1'b0;
        end else if (blink_tick) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end

        blank_mask_d = 4'b0000;
        if (phase_d) begin
            case (mode_d)
                ModeSetTh, ModeSetAh: blank_mask_d = 4'b1100;
                ModeSetTm, ModeSetAm: blank_mask_d = 4'b0011;
                default:              blank_mask_d = 4'b0000;
            endcase
        end

        // Ring only on the rising edge of match so a held time rings once
        match_d      = ({th1, th2, tm1, tm2} == {ah1, ah2, am1, am2});
        ring_set     = match_d & ~match_q & alarm_en_q & (mode_q == ModeClk);
        ring_timeout = ringing_q & sec_tick & ((ring_cnt_q + 8'd1) == RingLimit);
        ring_clr     = any_btn | ~alarm_en_d | (mode_d != ModeClk) | ring_timeout;
        ringing_d    = (ringing_q | ring_set) & ~ring_clr;

        // Clear wins over count; counter is held at zero whenever not ringing
        if (!ringing_d) begin
            ring_cnt_d = 8'd0;
        end else if (ringing_q && sec_tick) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
        end else begin
            ring_cnt_d = ring_cnt_q;
        end
    end

    // Registered outputs and auxiliary state
    always_ff @(posedge clk) begin
        if (rst) begin
            en_th_q      <= 1'b0;
            en_tm_q      <= 1'b0;
            en_ah_q      <= 1'b0;
            en_am_q      <= 1'b0;
            updown_q     <= 1'b0;
            hold_time_q  <= 1'b0;
            disp_alarm_q <= 1'b0;
            blank_mask_q <= 4'b0000;
            alarm_en_q   <= 1'b0;
            ringing_q    <= 1'b0;
            phase_q      <= 1'b0;
            ring_cnt_q   <= 8'd0;
            match_q      <= 1'b0;
        end else begin
            en_th_q      <= en_th_d;
            en_tm_q      <= en_tm_d;
            en_ah_q      <= en_ah_d;
            en_am_q      <= en_am_d;
            updown_q     <= updown_d;
            hold_time_q  <= hold_time_d;
            disp_alarm_q <= disp_alarm_d;
            blank_mask_q <= blank_mask_d;
            alarm_en_q   <= alarm_en_d;
            ringing_q    <= ringing_d;
            phase_q      <= phase_d;
            ring_cnt_q   <= ring_cnt_d;
            match_q      <= match_d;
        end
    end

    assign mode       = mode_q;
    assign en_th      = en_th_q;
    assign en_tm      = en_tm_q;
    assign en_ah      = en_ah_q;
    assign en_am      = en_am_q;
    assign updown     = updown_q;
    assign hold_time  = hold_time_q;
    assign disp_alarm = disp_alarm_q;
    assign blank_mask = blank_mask_q;
    assign alarm_en   = alarm_en_q;
    assign ringing    = ringing_q;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Bench for alarm_mode_controller: directed scenarios plus a randomized run
// checked against a mode/alarm reference model.
module tb_alarm_mode_controller;

    localparam int unsigned Ring = 3;

    // Button vectors ordered {center, right, left, up, down}
    localparam logic [4:0] BtnC = 5'b10000;
    localparam logic [4:0] BtnR = 5'b01000;
    localparam logic [4:0] BtnL = 5'b00100;
    localparam logic [4:0] BtnU = 5'b00010;
    localparam logic [4:0] BtnD = 5'b00001;

    localparam logic [4:0] WalkBtn  [7] = '{BtnC, BtnR, BtnR, BtnR, BtnR, BtnL, BtnC};
    localparam int         WalkMode [7] = '{1, 2, 3, 4, 1, 4, 0};

    logic       clk = 1'b0;
    logic       rst, up, down, left, right, center, sec_tick, blink_tick;
    logic [1:0] th1, ah1;
    logic [3:0] th2, tm2, ah2, am2;
    logic [2:0] tm1, am1;
    logic [2:0] mode;
    logic       en_th, en_tm, en_ah, en_am, updown, hold_time, disp_alarm;
    logic [3:0] blank_mask;
    logic       alarm_en, ringing;
    logic [15:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state (mode 0..4, active field 0 = none)
    int m_mode, m_en, m_cnt;
    bit m_updown, m_alarm_en, m_ringing, m_match, m_phase;

    always #5 clk = ~clk;

    alarm_mode_controller #(.RING_SECS(Ring)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .center(center), .sec_tick(sec_tick), .blink_tick(blink_tick),
        .th1(th1), .th2(th2), .tm1(tm1), .tm2(tm2),
        .ah1(ah1), .ah2(ah2), .am1(am1), .am2(am2),
        .mode(mode), .en_th(en_th), .en_tm(en_tm), .en_ah(en_ah), .en_am(en_am),
        .updown(updown), .hold_time(hold_time), .disp_alarm(disp_alarm),
        .blank_mask(blank_mask), .alarm_en(alarm_en), .ringing(ringing)
    );

    assign dut_vec = {mode, en_th, en_tm, en_ah, en_am, updown, hold_time, disp_alarm,
                      blank_mask, alarm_en, ringing};

    function automatic logic [15:0] exp_vec();
        logic [3:0] en;
        logic [3:0] blank;
        en = 4'b0000;
        if (m_en != 0) en = 4'b1000 >> (m_en - 1);
        blank = 4'b0000;
        if (m_phase && m_mode != 0) blank = (m_mode % 2 == 1) ? 4'b1100 : 4'b0011;
        return {3'(m_mode), en, m_updown, (m_mode == 1 || m_mode == 2), (m_mode >= 3),
                blank, m_alarm_en, m_ringing};
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit any, mt, set, tmo, clr, nae, nup, nring;
        int nm, nen, ncnt;
        if (rst) begin
            m_mode = 0; m_en = 0; m_cnt = 0;
            m_updown = 0; m_alarm_en = 0; m_ringing = 0; m_match = 0; m_phase = 0;
        end else begin
            any = up | down | left | right | center;
            nm = m_mode; nen = 0; nae = m_alarm_en; nup = m_updown;
            if (m_ringing && any) begin
                nm = m_mode;
            end else if (center) begin
                nm = (m_mode == 0) ? 1 : 0;
            end else if (right) begin
                if (m_mode != 0) nm = m_mode % 4 + 1;
            end else if (left) begin
                if (m_mode != 0) nm = (m_mode + 2) % 4 + 1;
            end else if (up) begin
                if (m_mode == 0) nae = !m_alarm_en;
                else begin nen = m_mode; nup = 1; end
            end else if (down) begin
                if (m_mode != 0) begin nen = m_mode; nup = 0; end
            end
            mt = (th1 == ah1) && (th2 == ah2) && (tm1 == am1) && (tm2 == am2);
            set = mt && !m_match && m_alarm_en && m_mode == 0;
            tmo = m_ringing && sec_tick && (m_cnt + 1 == int'(Ring));
            clr = any || !nae || nm != 0 || tmo;
            nring = (m_ringing || set) && !clr;
            ncnt = !nring ? 0 : ((m_ringing && sec_tick) ? m_cnt + 1 : m_cnt);
            if (nm != m_mode) m_phase = 0;
            else if (blink_tick) m_phase = !m_phase;
            m_mode = nm; m_en = nen; m_alarm_en = nae; m_updown = nup;
            m_ringing = nring; m_cnt = ncnt; m_match = mt;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {center, right, left, up, down} = b;
        tick();
        {center, right, left, up, down} = 5'b0;
    endtask

    task automatic set_time(input int h1, input int h2, input int m1, input int m2);
        th1 = 2'(h1); th2 = 4'(h2); tm1 = 3'(m1); tm2 = 4'(m2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (dut_vec !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0000", dut_vec);
        end
    endtask

    task automatic test_mode_walk();
        for (int i = 0; i < 7; i++) begin
            press(WalkBtn[i]);
            checks++;
            if (mode !== 3'(WalkMode[i])) begin
                errors++;
                $display("FAIL walk_mode step %0d: got %0d expected %0d", i, mode, WalkMode[i]);
            end
            checks++;
            if ({hold_time, disp_alarm} !==
                {WalkMode[i] == 1 || WalkMode[i] == 2, WalkMode[i] >= 3}) begin
                errors++;
                $display("FAIL walk_flags step %0d: got hold=%b disp=%b for mode %0d",
                         i, hold_time, disp_alarm, WalkMode[i]);
            end
        end
    endtask

    task automatic test_adjust();
        press(BtnC);
        press(BtnR);
        press(BtnU);
        checks++;
        if ({en_th, en_tm, en_ah, en_am, updown} !== 5'b01001) begin
            errors++;
            $display("FAIL adjust_up: got en=%b%b%b%b ud=%b expected en=0100 ud=1",
                     en_th, en_tm, en_ah, en_am, updown);
        end
        tick();
        checks++;
        if ({en_th, en_tm, en_ah, en_am, updown} !== 5'b00001) begin
            errors++;
            $display("FAIL adjust_one_cycle: got en=%b%b%b%b ud=%b expected en=0000 ud=1",
                     en_th, en_tm, en_ah, en_am, updown);
        end
        press(BtnD);
        checks++;
        if ({en_th, en_tm, en_ah, en_am, updown} !== 5'b01000) begin
            errors++;
            $display("FAIL adjust_down: got en=%b%b%b%b ud=%b expected en=0100 ud=0",
                     en_th, en_tm, en_ah, en_am, updown);
        end
        press(BtnC);
        press(BtnU);
        checks++;
        if ({en_th, en_tm, en_ah, en_am, alarm_en} !== 5'b00001) begin
            errors++;
            $display("FAIL clk_up: got en=%b%b%b%b alarm_en=%b expected en=0000 alarm_en=1",
                     en_th, en_tm, en_ah, en_am, alarm_en);
        end
        press(BtnU);
        press(BtnD);
        checks++;
        if ({en_th, en_tm, en_ah, en_am, alarm_en} !== 5'b00000) begin
            errors++;
            $display("FAIL clk_down: got en=%b%b%b%b alarm_en=%b expected all 0",
                     en_th, en_tm, en_ah, en_am, alarm_en);
        end
    endtask

    task automatic test_priority();
        press(BtnC);
        press(BtnC | BtnR);
        checks++;
        if ({mode, en_th, en_tm, en_ah, en_am} !== 7'b000_0000) begin
            errors++;
            $display("FAIL prio_center_right: got mode=%0d en=%b%b%b%b expected mode=0 en=0000",
                     mode, en_th, en_tm, en_ah, en_am);
        end
        press(BtnC);
        press(BtnR);
        press(BtnR);
        press(BtnU | BtnD);
        checks++;
        if ({mode, en_th, en_tm, en_ah, en_am, updown} !== 8'b011_0010_1) begin
            errors++;
            $display("FAIL prio_up_down: got mode=%0d en=%b%b%b%b ud=%b expected 3 0010 1",
                     mode, en_th, en_tm, en_ah, en_am, updown);
        end
        press(BtnC);
    endtask

    task automatic test_ring();
        ah1 = 2'd0; ah2 = 4'd7; am1 = 3'd3; am2 = 4'd0;
        set_time(0, 0, 0, 0);
        press(BtnU);
        set_time(0, 7, 2, 9);
        tick();
        checks++;
        if ({alarm_en, ringing} !== 2'b10) begin
            errors++;
            $display("FAIL ring_before: got alarm_en=%b ringing=%b expected 1 0", alarm_en, ringing);
        end
        set_time(0, 7, 3, 0);
        tick();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL ring_match: got ringing=%b expected 1", ringing);
        end
        tick();
        tick();
        press(BtnC);
        checks++;
        if ({mode, ringing, alarm_en} !== 5'b000_0_1) begin
            errors++;
            $display("FAIL ring_ack: got mode=%0d ringing=%b alarm_en=%b expected 0 0 1",
                     mode, ringing, alarm_en);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL ring_no_rering: got ringing=%b expected 0", ringing);
        end
    endtask

    task automatic test_timeout();
        set_time(0, 7, 3, 1);
        tick();
        set_time(0, 7, 3, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            checks++;
            if (ringing !== (k < 2)) begin
                errors++;
                $display("FAIL timeout tick %0d: got ringing=%b expected %b", k, ringing, k < 2);
            end
        end
        set_time(0, 7, 3, 1);
        tick();
        set_time(0, 7, 3, 0);
        tick();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL rering: got ringing=%b expected 1", ringing);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_vec !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_ring: got %h expected 0000", dut_vec);
        end
    endtask

    task automatic test_blink();
        press(BtnC);
        press(BtnL);
        blink_tick = 1'b1;
        tick();
        blink_tick = 1'b0;
        checks++;
        if ({mode, blank_mask} !== 7'b100_0011) begin
            errors++;
            $display("FAIL blink_am: got mode=%0d blank=%b expected 4 0011", mode, blank_mask);
        end
        press(BtnR);
        checks++;
        if ({mode, blank_mask} !== 7'b001_0000) begin
            errors++;
            $display("FAIL blink_cleared: got mode=%0d blank=%b expected 1 0000", mode, blank_mask);
        end
        blink_tick = 1'b1;
        tick();
        blink_tick = 1'b0;
        checks++;
        if (blank_mask !== 4'b1100) begin
            errors++;
            $display("FAIL blink_th: got blank=%b expected 1100", blank_mask);
        end
        press(BtnC);
        checks++;
        if (blank_mask !== 4'b0000) begin
            errors++;
            $display("FAIL blink_clk: got blank=%b expected 0000", blank_mask);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) {center, right, left, up, down} = 5'($urandom);
            else {center, right, left, up, down} = 5'b0;
            sec_tick   = ($urandom_range(0, 3) == 0);
            blink_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                ah1 = 2'($urandom); ah2 = 4'($urandom); am1 = 3'($urandom); am2 = 4'($urandom);
            end
            case ($urandom_range(0, 5))
                0:       set_time(ah1 ^ 2'd1, ah2, am1, am2);
                1:       set_time(ah1, ah2, am1, am2 ^ 4'd1);
                5:       set_time($urandom, $urandom, $urandom, $urandom);
                default: set_time(ah1, ah2, am1, am2);
            endcase
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        rst = 1'b0;
        {center, right, left, up, down} = 5'b0;
        sec_tick = 1'b0;
        blink_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {center, right, left, up, down} = 5'b0;
        sec_tick = 1'b0;
        blink_tick = 1'b0;
        set_time(0, 0, 0, 0);
        ah1 = 2'd1; ah2 = 4'd2; am1 = 3'd0; am2 = 4'd0;
        test_reset();
        test_mode_walk();
        test_adjust();
        test_priority();
        test_ring();
        test_timeout();
        test_blink();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
